// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the sample-rate-converter controller: instruction field
// layout, default widths and the program-store state encoding.
package src_ctrl_pkg;

  localparam int VEC_ID_W       = 3;
  localparam int REGFILE_ADDR_W = 4;
  localparam int DATA_ADDR_W    = 6;
  localparam int INSTR_ADDR_W   = 5;
  localparam int INSTR_W        = 2 + VEC_ID_W + 2*REGFILE_ADDR_W + 3*DATA_ADDR_W;

  // Field LSB positions, coef_ptr at bit 0 up to lstg_f at the MSB.
  localparam int COEF_PTR_LSB   = 0;
  localparam int DATA_LPTR_LSB  = COEF_PTR_LSB + DATA_ADDR_W;
  localparam int DATA_UPTR_LSB  = DATA_LPTR_LSB + DATA_ADDR_W;
  localparam int ERROR_REG_LSB  = DATA_UPTR_LSB + DATA_ADDR_W;
  localparam int RESULT_REG_LSB = ERROR_REG_LSB + REGFILE_ADDR_W;
  localparam int VECTOR_ID_LSB  = RESULT_REG_LSB + REGFILE_ADDR_W;
  localparam int UPSE_F_BIT     = VECTOR_ID_LSB + VEC_ID_W;
  localparam int LSTG_F_BIT     = UPSE_F_BIT + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// Single-write, single-read synchronous RAM with a registered read port that
// holds its last value when no read is requested. The array is never reset.
module instr_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Program store for the sample-rate-converter controller: serial load of
// instruction words, then one-cycle-latency fetch by program counter.
module instr_mem
  import src_ctrl_pkg::*;
#(
  parameter int VEC_ID_WIDTH       = src_ctrl_pkg::VEC_ID_W,
  parameter int REGFILE_ADDR_WIDTH = src_ctrl_pkg::REGFILE_ADDR_W,
  parameter int DATA_ADDR_WIDTH    = src_ctrl_pkg::DATA_ADDR_W,
  parameter int INSTR_ADDR_WIDTH   = src_ctrl_pkg::INSTR_ADDR_W,
  parameter int INSTR_WIDTH        = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + 3*DATA_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog,
  input  logic                        load_valid,
  input  logic [INSTR_WIDTH-1:0]      load_word,
  output logic                        load_ready,
  input  logic                        fetch,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  output logic [INSTR_WIDTH-1:0]      instr_word,
  output logic                        instr_valid,
  output logic                        last,
  output logic [INSTR_ADDR_WIDTH:0]   prog_len,
  output logic                        oob,
  output logic                        bad_ptr
);

  localparam int DEPTH = 2**INSTR_ADDR_WIDTH;
  localparam int LEN_W = INSTR_ADDR_WIDTH + 1;

  state_t state, state_nxt;
  logic [LEN_W-1:0] wptr, wptr_nxt;
  logic [DATA_ADDR_WIDTH-1:0] uptr, lptr;
  logic load_entry, xfer, word_bad, fetch_run, pc_legal;
  logic vld_p1, last_p1, zero_p1;
  logic [INSTR_WIDTH-1:0] rd_word_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (prog) state_nxt = ST_LOAD;
      ST_LOAD: if (!prog) state_nxt = (wptr != '0) ? ST_RUN : ST_IDLE;
      ST_RUN:  if (prog) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign uptr       = load_word[3*DATA_ADDR_WIDTH-1 -: DATA_ADDR_WIDTH];
  assign lptr       = load_word[2*DATA_ADDR_WIDTH-1 -: DATA_ADDR_WIDTH];
  assign word_bad   = lptr > uptr;
  assign load_entry = (state_nxt == ST_LOAD) && (state != ST_LOAD);
  assign xfer       = (state == ST_LOAD) && load_valid && load_ready;
  assign fetch_run  = (state == ST_RUN) && fetch;
  assign pc_legal   = {1'b0, pc} < wptr;

  // wptr stops at DEPTH because load_ready drops there; it doubles as prog_len.
  always_comb begin
    wptr_nxt = wptr;
    if (load_entry)  wptr_nxt = '0;
    else if (xfer)   wptr_nxt = wptr + LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      wptr <= '0;
      load_ready <= 1'b0;
      bad_ptr <= 1'b0;
      oob <= 1'b0;
    end else begin
      state <= state_nxt;
      wptr <= wptr_nxt;
      load_ready <= (state_nxt == ST_LOAD) && (wptr_nxt < LEN_W'(DEPTH));
      bad_ptr <= load_entry ? 1'b0 : (bad_ptr | (xfer & word_bad));
      oob <= load_entry ? 1'b0 : (oob | (fetch_run & ~pc_legal));
    end
  end

  instr_ram #(
    .ADDR_W(INSTR_ADDR_WIDTH),
    .DATA_W(INSTR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (xfer),
    .waddr(wptr[INSTR_ADDR_WIDTH-1:0]),
    .wdata(load_word),
    .re   (fetch_run & pc_legal),
    .raddr(pc),
    .rdata(rd_word_p1)
  );

  // Read stage p1: zero_p1 masks the RAM output after reset or an out-of-range fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      last_p1 <= 1'b0;
      zero_p1 <= 1'b1;
    end else begin
      vld_p1 <= fetch_run & pc_legal;
      if (fetch_run) begin
        last_p1 <= pc_legal && ({1'b0, pc} == wptr - LEN_W'(1));
        zero_p1 <= ~pc_legal;
      end
    end
  end

  assign instr_word  = zero_p1 ? '0 : rd_word_p1;
  assign instr_valid = vld_p1;
  assign last        = last_p1;
  assign prog_len    = wptr;

endmodule

// File: doc/instr_mem.md
# instr_mem

Program store for the sample-rate-converter controller. Accepts allocation instruction words serially while `prog` is high, counts them, and serves them back to the controller's instruction-fetch stage (`fetch`/`pc` → `instr_word`) with one-cycle read latency. It sits directly upstream of `top` and replaces the behavioural program ROM.

## Interface
Parameters:
- `VEC_ID_WIDTH`, 3: vector id field width
- `REGFILE_ADDR_WIDTH`, 4: result/error register field width
- `DATA_ADDR_WIDTH`, 6: data/coef pointer field width
- `INSTR_ADDR_WIDTH`, 5: program address width; depth = 2**INSTR_ADDR_WIDTH (32)
- `INSTR_WIDTH`, 1+1+VEC_ID_WIDTH+2*REGFILE_ADDR_WIDTH+3*DATA_ADDR_WIDTH (31): instruction word width

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  async reset, active-high
- `prog`  in  1  load mode; level-sensitive
- `load_valid`  in  1  load word present
- `load_word`  in  INSTR_WIDTH  instruction being loaded
- `load_ready`  out  1  store can accept a word
- `fetch`  in  1  controller read request
- `pc`  in  INSTR_ADDR_WIDTH  read address
- `instr_word`  out  INSTR_WIDTH  fetched instruction
- `instr_valid`  out  1  `instr_word` updated this cycle from a legal address
- `last`  out  1  fetched word is the final loaded instruction
- `prog_len`  out  INSTR_ADDR_WIDTH+1  number of loaded words
- `oob`  out  1  sticky: fetch at `pc >= prog_len`
- `bad_ptr`  out  1  sticky: a loaded word had `data_lptr > data_uptr`

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE→LOAD when `prog`=1. Entry clears `wptr`, `prog_len`, `bad_ptr`, `oob`.
  - LOAD→RUN when `prog`=0 and `prog_len`>0.
  - LOAD→IDLE when `prog`=0 and `prog_len`=0.
  - RUN→LOAD when `prog`=1.
- LOAD:
  - `load_ready` = (`wptr` < depth).
  - Transfer occurs when `load_valid`&&`load_ready`: `mem[wptr]`←`load_word`, `wptr`+1, `prog_len`+1.
  - `load_valid` with `load_ready`=0 is dropped silently; memory and counters unchanged.
- Field check on every transfer:
  - `data_uptr` = bits [3*DATA_ADDR_WIDTH-1 : 2*DATA_ADDR_WIDTH].
  - `data_lptr` = bits [2*DATA_ADDR_WIDTH-1 : DATA_ADDR_WIDTH].
  - If lptr > uptr, `bad_ptr` is set; the word is still stored.
- RUN, on `fetch`=1:
  - If `pc` < `prog_len`: `instr_word`←`mem[pc]`, `instr_valid`=1, `last`=(`pc`==`prog_len`-1).
  - Otherwise: `instr_word`←0, `instr_valid`=0, `last`=0, `oob` set.
- RUN, `fetch`=0: `instr_word` and `last` hold; `instr_valid`=0.
- `fetch` in IDLE/LOAD is ignored: outputs hold, `instr_valid`=0.
- `prog_len` saturates at depth (6-bit for depth 32). `wptr` never wraps.
- Memory array is not reset. Contents survive reset, but `prog_len`=0 makes them unreachable.

## Timing
- Reset values: state IDLE, `load_ready`=0, `instr_word`=0, `instr_valid`=0, `last`=0, `prog_len`=0, `oob`=0, `bad_ptr`=0.
- `load_ready` is registered from `wptr`/state. It rises one cycle after LOAD entry and falls on the cycle after the depth-th transfer.
- Write is accepted at the clock edge where `load_valid`&&`load_ready`. `prog_len` reflects it after that edge.
- Read latency is 1 clock: `fetch` sampled at edge N, `instr_word`/`instr_valid`/`last` valid after edge N. This matches the controller, which registers `instr_word` on the following edge.
- Back-to-back fetches each cycle are supported at full rate.
- `prog` toggling mid-transfer: the state change and any transfer on the same edge both take effect. On a LOAD entry edge no write occurs.
- `rst` mid-LOAD aborts immediately: state IDLE, `prog_len`=0.

## Structure
- Shared package `src_ctrl_pkg`:
  - field widths and `INSTR_WIDTH`
  - field bit offsets (`lstg_f` MSB, `upse_f`, `vector_id`, `result_reg`, `error_reg`, `data_uptr`, `data_lptr`, `coef_ptr` LSB)
  - state encoding
- The controller's instruction-fetch decode imports the same offsets.
- One sub-module: `instr_ram`, a 1W/1R synchronous RAM (depth 2**INSTR_ADDR_WIDTH, registered read). No reset on the array.

## Test plan
- Reset, then `prog`=1 and 3 words with `load_valid` every cycle, then `prog`=0 → `prog_len`=3, state RUN, `bad_ptr`=0.
- Fetch `pc`=0,1,2 on consecutive cycles → `instr_word` equals words 0,1,2 one cycle later, `instr_valid`=1 each, `last`=1 only for `pc`=2.
- Load 33 words back-to-back → `load_ready`=0 after 32nd transfer, 33rd dropped, `prog_len`=32, `mem[0]` unchanged.
- Fetch `pc`=5 with `prog_len`=3 → `instr_word`=0, `instr_valid`=0, `oob`=1 and stays 1 until next LOAD entry.
- Load a word with `data_lptr`=10, `data_uptr`=4 → `bad_ptr`=1, word still readable at its address.
- Assert `rst` for 1 cycle after 2 of 4 loaded words → all outputs at reset values, `prog_len`=0, a subsequent fetch gives `instr_valid`=0.
